// File: rtl/select_reg_stack_if.sv
// Request/status bundle between the control sequencer (master) and the
// select register with return stack (slave).
interface select_reg_stack_if #(
  parameter int WIDTH       = 12,
  parameter int NUM_SRC     = 4,
  parameter int STACK_DEPTH = 4
);
  localparam int CW = $clog2(STACK_DEPTH + 1);

  logic                     hold;
  logic [NUM_SRC-1:0]       src_load;
  logic [NUM_SRC*WIDTH-1:0] src_data;
  logic                     inc_en;
  logic                     dec_en;
  logic                     push_en;
  logic                     pop_en;
  logic                     err_clear;
  logic [WIDTH-1:0]         reg_select_value;
  logic                     select_changed;
  logic [CW-1:0]            stack_count;
  logic                     stack_full;
  logic                     stack_empty;
  logic                     overflow_err;
  logic                     underflow_err;

  modport master (
    output hold, src_load, src_data, inc_en, dec_en, push_en, pop_en, err_clear,
    input  reg_select_value, select_changed, stack_count, stack_full, stack_empty,
           overflow_err, underflow_err
  );

  modport slave (
    input  hold, src_load, src_data, inc_en, dec_en, push_en, pop_en, err_clear,
    output reg_select_value, select_changed, stack_count, stack_full, stack_empty,
           overflow_err, underflow_err
  );
endinterface

// File: rtl/select_reg_stack.sv
// Select/address register with prioritised source load, inc/dec and a LIFO
// return stack for call/return style save and restore.
module select_reg_stack #(
  parameter int WIDTH       = 12,
  parameter int NUM_SRC     = 4,
  parameter int STACK_DEPTH = 4,
  parameter int STEP        = 1
) (
  input logic               clk,
  input logic               resetn,
  select_reg_stack_if.slave bus
);
  localparam int CW = $clog2(STACK_DEPTH + 1);
  localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [WIDTH-1:0]                  sel_q, sel_d, top, src_val;
  logic [STACK_DEPTH-1:0][WIDTH-1:0] stack_q;
  logic [CW-1:0]                     count_q;
  logic                              changed_q, ovf_q, unf_q;
  logic                              empty, full, src_hit;
  logic                              do_pop, do_swap, do_push, ovf_set, unf_set;
  logic [IW-1:0]                     top_idx, push_idx;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(STACK_DEPTH));
  assign top_idx  = IW'(count_q - CW'(1));
  assign push_idx = IW'(count_q);
  assign top      = stack_q[top_idx];

  // Walk from the highest index down so the lowest set source wins.
  always_comb begin
    src_hit = 1'b0;
    src_val = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (bus.src_load[i]) begin
        src_hit = 1'b1;
        src_val = bus.src_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    do_pop  = bus.pop_en & ~empty & ~bus.push_en;
    do_swap = bus.pop_en & bus.push_en & ~empty;
    // A push alongside a failed pop (empty stack) still lands.
    do_push = bus.push_en & ~full & (~bus.pop_en | empty);
    ovf_set = bus.push_en & ~bus.pop_en & full;
    unf_set = bus.pop_en & empty;

    sel_d = sel_q;
    if (do_pop | do_swap)              sel_d = top;
    else if (src_hit)                  sel_d = src_val;
    else if (bus.inc_en & ~bus.dec_en) sel_d = sel_q + WIDTH'(STEP);
    else if (bus.dec_en & ~bus.inc_en) sel_d = sel_q - WIDTH'(STEP);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      sel_q     <= '0;
      stack_q   <= '0;
      count_q   <= '0;
      changed_q <= 1'b0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      if (bus.err_clear) begin
        ovf_q <= 1'b0;
        unf_q <= 1'b0;
      end
      if (bus.hold) begin
        changed_q <= 1'b0;
      end else begin
        sel_q     <= sel_d;
        changed_q <= (sel_d != sel_q);
        // Later assignment lets a new error beat a same-cycle clear.
        if (ovf_set) ovf_q <= 1'b1;
        if (unf_set) unf_q <= 1'b1;
        if (do_swap)      stack_q[top_idx]  <= sel_q;
        else if (do_push) stack_q[push_idx] <= sel_q;
        if (do_pop)       count_q <= count_q - CW'(1);
        else if (do_push) count_q <= count_q + CW'(1);
      end
    end
  end

  assign bus.reg_select_value = sel_q;
  assign bus.select_changed   = changed_q;
  assign bus.stack_count      = count_q;
  assign bus.stack_full       = full;
  assign bus.stack_empty      = empty;
  assign bus.overflow_err     = ovf_q;
  assign bus.underflow_err    = unf_q;
endmodule

// File: tb/tb_select_reg_stack.sv
// Directed bench for select_reg_stack: reset, priority, wrap, call/return,
// overflow/underflow, swap and hold.
module tb_select_reg_stack;
  localparam int WIDTH = 12, NUM_SRC = 4, DEPTH = 4;

  logic clk, resetn;
  int   passed = 0, total = 0;

  select_reg_stack_if #(.WIDTH(WIDTH), .NUM_SRC(NUM_SRC), .STACK_DEPTH(DEPTH)) bus ();

  select_reg_stack #(.WIDTH(WIDTH), .NUM_SRC(NUM_SRC), .STACK_DEPTH(DEPTH), .STEP(1)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0o expected=%0o", tag, obs, exp);
  endtask

  task automatic idle();
    bus.src_load  = '0;
    bus.src_data  = '0;
    bus.inc_en    = 1'b0;
    bus.dec_en    = 1'b0;
    bus.push_en   = 1'b0;
    bus.pop_en    = 1'b0;
    bus.err_clear = 1'b0;
  endtask

  task automatic src(input int i, input logic [WIDTH-1:0] v);
    bus.src_load[i] = 1'b1;
    bus.src_data[i*WIDTH +: WIDTH] = v;
  endtask

  // Apply the currently driven requests for one edge, then sample just after it.
  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic load(input logic [WIDTH-1:0] v);
    src(0, v);
    tick();
  endtask

  initial begin
    resetn   = 1'b0;
    bus.hold = 1'b0;
    idle();
    #1;

    // Reset with requests asserted
    src(0, 12'o0777); bus.inc_en = 1'b1; bus.push_en = 1'b1;
    @(posedge clk); #1;
    src(0, 12'o0777); bus.inc_en = 1'b1; bus.push_en = 1'b1;
    tick();
    chk("rst_reg",     bus.reg_select_value, 0);
    chk("rst_count",   bus.stack_count, 0);
    chk("rst_empty",   bus.stack_empty, 1);
    chk("rst_full",    bus.stack_full, 0);
    chk("rst_ovf",     bus.overflow_err, 0);
    chk("rst_unf",     bus.underflow_err, 0);
    chk("rst_changed", bus.select_changed, 0);
    resetn = 1'b1;

    // Source priority: lowest set index wins over others and over inc
    src(1, 12'o1234); src(2, 12'o7777); bus.inc_en = 1'b1;
    tick();
    chk("prio_reg",     bus.reg_select_value, 12'o1234);
    chk("prio_changed", bus.select_changed, 1);

    // Wrap around both ways, then inc&dec cancel
    src(3, 12'o7777); tick();
    bus.inc_en = 1'b1; tick();
    chk("wrap_inc",     bus.reg_select_value, 12'o0000);
    chk("wrap_inc_chg", bus.select_changed, 1);
    bus.dec_en = 1'b1; tick();
    chk("wrap_dec",     bus.reg_select_value, 12'o7777);
    bus.inc_en = 1'b1; bus.dec_en = 1'b1; tick();
    chk("cancel_reg",   bus.reg_select_value, 12'o7777);
    chk("cancel_chg",   bus.select_changed, 0);
    load(12'o7777);
    chk("equal_load_chg", bus.select_changed, 0);

    // Call / return
    load(12'o0100);
    bus.push_en = 1'b1; src(0, 12'o2000); tick();
    chk("call_reg",   bus.reg_select_value, 12'o2000);
    chk("call_count", bus.stack_count, 1);
    chk("call_empty", bus.stack_empty, 0);
    bus.pop_en = 1'b1; src(1, 12'o4444); tick();
    chk("ret_reg",    bus.reg_select_value, 12'o0100);
    chk("ret_count",  bus.stack_count, 0);
    chk("ret_empty",  bus.stack_empty, 1);
    chk("ret_chg",    bus.select_changed, 1);

    // Overflow: pushes 1..4 fill the stack, fifth push (of 5) is dropped
    load(12'o0001);
    for (int k = 2; k <= 6; k++) begin
      bus.push_en = 1'b1; src(0, WIDTH'(k)); tick();
    end
    chk("ovf_full",  bus.stack_full, 1);
    chk("ovf_count", bus.stack_count, DEPTH);
    chk("ovf_err",   bus.overflow_err, 1);
    chk("ovf_reg",   bus.reg_select_value, 6);
    bus.pop_en = 1'b1; tick();
    chk("ovf_top",    bus.reg_select_value, 4);
    chk("ovf_sticky", bus.overflow_err, 1);
    chk("pop_notfull", bus.stack_full, 0);
    for (int k = 3; k >= 1; k--) begin
      bus.pop_en = 1'b1; tick();
      chk("pop_seq", bus.reg_select_value, k);
    end
    chk("pop_empty", bus.stack_empty, 1);

    // Underflow
    bus.pop_en = 1'b1; tick();
    chk("unf_err", bus.underflow_err, 1);
    chk("unf_reg", bus.reg_select_value, 1);
    chk("unf_chg", bus.select_changed, 0);
    bus.pop_en = 1'b1; src(2, 12'o0070); tick();
    chk("unf_fallthru", bus.reg_select_value, 12'o0070);
    // Clear and new error in the same cycle: new error wins
    bus.err_clear = 1'b1; bus.pop_en = 1'b1; tick();
    chk("clr_ovf",    bus.overflow_err, 0);
    chk("clr_unf_set", bus.underflow_err, 1);
    bus.err_clear = 1'b1; tick();
    chk("clr_unf", bus.underflow_err, 0);

    // Push & pop on empty: pop fails, push lands, reg takes inc path
    bus.push_en = 1'b1; bus.pop_en = 1'b1; bus.inc_en = 1'b1; tick();
    chk("pp_empty_unf",   bus.underflow_err, 1);
    chk("pp_empty_count", bus.stack_count, 1);
    chk("pp_empty_reg",   bus.reg_select_value, 12'o0071);
    bus.pop_en = 1'b1; tick();
    chk("pp_empty_top",   bus.reg_select_value, 12'o0070);
    bus.err_clear = 1'b1; tick();

    // Swap
    load(12'o0005);
    bus.push_en = 1'b1; src(0, 12'o0003); tick();
    bus.push_en = 1'b1; bus.pop_en = 1'b1; tick();
    chk("swap_reg",   bus.reg_select_value, 12'o0005);
    chk("swap_count", bus.stack_count, 1);
    chk("swap_chg",   bus.select_changed, 1);
    bus.pop_en = 1'b1; tick();
    chk("swap_top",   bus.reg_select_value, 12'o0003);

    // Hold freezes state, forces changed low, suppresses errors
    bus.hold = 1'b1;
    src(0, 12'o1111); bus.push_en = 1'b1; tick();
    chk("hold_reg",   bus.reg_select_value, 12'o0003);
    chk("hold_chg",   bus.select_changed, 0);
    chk("hold_count", bus.stack_count, 0);
    bus.pop_en = 1'b1; tick();
    chk("hold_no_unf", bus.underflow_err, 0);
    bus.hold = 1'b0;
    bus.pop_en = 1'b1; tick();
    bus.hold = 1'b1; bus.err_clear = 1'b1; tick();
    chk("hold_errclr", bus.underflow_err, 0);

    // Reset beats hold
    resetn = 1'b0; tick();
    chk("rst_over_hold", bus.reg_select_value, 0);
    resetn = 1'b1; bus.hold = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
